result_display_driver: RTL and testbench
========================================

Name: result_display_driver

Overview:
Consumes sign-magnitude results from the calculator datapath (3-bit magnitude, sign and zero flags) through a valid/ready handshake. It latches each accepted result and drives a time-multiplexed 2-digit seven-segment display: digit 0 shows the magnitude and digit 1 shows the sign. A minimum hold period stops results from flickering past faster than they can be read, and the block flags results whose zero flag disagrees with their magnitude.

Parameters:
REFRESH_DIV, 1000, clock cycles per digit slot; legal range >= 2.
HOLD_SCANS, 4, digit-slot toggles after an accept before res_ready re-asserts; legal range >= 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
res_valid  in  1  result offered
res_ready  out  1  block can accept a result
res_mag  in  3  result magnitude, 0..7
res_sign  in  1  result sign, 1 = negative
res_zero  in  1  result-is-zero flag
clr  in  1  synchronous display clear
seg  out  7  segments {g,f,e,d,c,b,a}, active-high
an  out  2  digit enables, one-hot active-high; an[0] = magnitude digit, an[1] = sign digit
err  out  1  last accepted result was inconsistent

Behaviour:
- Clocking and reset: single clock domain; rst_n is asynchronous, active-low.
- Reset values: state BLANK, res_ready=1, seg=7'h00, an=2'b00, err=0, divider=0, digit_sel=0, hold count=0, latched mag/sign=0.
- Handshake: a transfer occurs on a rising edge where res_valid=1 and res_ready=1.
  - res_ready = (state==BLANK or hold complete) and !clr; it is combinational from registers and clr only.
  - res_valid may stay asserted while res_ready=0; it is ignored until res_ready=1.
- FSM states: BLANK and SHOW.
  - BLANK: an=00, seg=00. A transfer moves to SHOW.
  - SHOW: scans both digits. A transfer reloads the latch and stays in SHOW. clr=1 moves to BLANK.
  - clr has priority over a transfer. clr in BLANK is a no-op.
- On every transfer:
  - Latch mag and sign.
  - err <= (res_zero && res_mag!=0) || (!res_zero && res_mag==0).
  - divider <= 0, digit_sel <= 0 (magnitude), hold count <= 0.
  - Zero normalisation: if res_zero=1, latched sign is forced to 0 and latched mag to 0.
- Latency: seg and an are decoded combinationally from registered state, so the new result is visible in the cycle right after the accepting edge.
- Scan divider (SHOW only):
  - The divider counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_sel toggles and hold count increments, saturating at HOLD_SCANS.
  - Hold is complete when hold count == HOLD_SCANS.
- Decoding:
  - an = digit_sel ? 2'b10 : 2'b01.
  - Magnitude digit: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07 (hex). If err=1, it shows 'E' = 79.
  - Sign digit: 40 ('-') when latched sign=1 and err=0; otherwise 00.
- err holds until the next transfer, clr, or reset. clr clears err.
- rst_n asserted mid-scan or mid-hold returns every register to its reset value immediately.
- Counter widths: clog2 of REFRESH_DIV and HOLD_SCANS+1. No overflow is possible because of the saturate/wrap rules above.

Test Plan (REFRESH_DIV=4, HOLD_SCANS=2):
1. Reset -> res_ready=1, an=00, seg=00, err=0; res_valid low for 20 cycles -> outputs unchanged.
2. Transfer mag=5 sign=1 zero=0 -> next cycle an=01 seg=6D, res_ready=0.
   - 4 cycles later: an=10, seg=40.
   - 4 cycles after that (second toggle): res_ready=1, an=01, seg=6D.
3. Transfer mag=0 sign=1 zero=1 -> sign digit seg=00 (normalised), magnitude seg=3F, err=0.
4. Transfer mag=0 zero=0 -> err=1, magnitude seg=79, sign seg=00. Then transfer mag=3 sign=0 zero=0 -> err=0, seg=4F.
5. res_valid held high with mag=2 during hold -> no transfer, display unchanged. Transfer occurs on the first cycle res_ready=1; seg=5B on the next cycle.
6. clr=1 with res_valid=1 in the same cycle -> res_ready=0, no transfer, state BLANK (an=00, seg=00).
   - Separately: rst_n pulsed low mid-scan -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/result_display_driver.sv
// -----------------------------------------------------------------------------
// result_display_driver
//
// Accepts sign-magnitude results from the calculator datapath over a
// valid/ready handshake, latches them, and drives a time-multiplexed 2-digit
// seven-segment display (digit 0 = magnitude, digit 1 = sign). After each
// accepted result the block withholds res_ready for HOLD_SCANS digit-slot
// toggles so a value stays on the display long enough to be read. Results
// whose zero flag disagrees with their magnitude raise err and show 'E'.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   HOLD_SCANS   digit-slot toggles after an accept before res_ready returns (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   res_valid  result offered
//   res_ready  block can accept a result
//   res_mag    result magnitude 0..7
//   res_sign   result sign, 1 = negative
//   res_zero   result-is-zero flag
//   clr        synchronous display clear (wins over a transfer)
//   seg        segments {g,f,e,d,c,b,a}, active-high
//   an         digit enables, one-hot; an[0] = magnitude, an[1] = sign
//   err        last accepted result was inconsistent
// -----------------------------------------------------------------------------
module result_display_driver #(
   parameter int REFRESH_DIV = 1000,
   parameter int HOLD_SCANS  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       res_valid,
   output logic       res_ready,
   input  logic [2:0] res_mag,
   input  logic       res_sign,
   input  logic       res_zero,
   input  logic       clr,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int DIV_W  = $clog2(REFRESH_DIV);
   localparam int HOLD_W = $clog2(HOLD_SCANS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(HOLD_SCANS);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q;
   logic              dsel_q;
   logic [HOLD_W-1:0] hold_q;
   logic [2:0]        mag_q;
   logic              sign_q;
   logic              err_q;
   logic              xfer;
   logic              hold_done;

   function automatic logic [6:0] mag_to_seg(input logic [2:0] m);
      logic [6:0] s;
      case (m)
         3'd0:    s = 7'h3F;
         3'd1:    s = 7'h06;
         3'd2:    s = 7'h5B;
         3'd3:    s = 7'h4F;
         3'd4:    s = 7'h66;
         3'd5:    s = 7'h6D;
         3'd6:    s = 7'h7D;
         default: s = 7'h07;
      endcase
      return s;
   endfunction

   assign hold_done = (hold_q == HOLD_DONE);
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // res_ready depends only on registers and clr, so a source may hold
   // res_valid high through the hold window without creating a comb loop.
   always_comb begin
      state_d   = state_q;
      an        = 2'b00;
      seg       = 7'h00;
      res_ready = ((state_q == BLANK) || hold_done) && !clr;
      xfer      = res_valid && res_ready;
      case (state_q)
         BLANK: begin
            if (xfer) begin
               state_d = SHOW;
            end
         end
         SHOW: begin
            an = dsel_q ? 2'b10 : 2'b01;
            if (dsel_q) begin
               seg = (sign_q && !err_q) ? 7'h40 : 7'h00;
            end else begin
               seg = err_q ? 7'h79 : mag_to_seg(mag_q);
            end
            if (clr) begin
               state_d = BLANK;
            end
         end
         default: state_d = BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         dsel_q <= 1'b0;
         hold_q <= '0;
         mag_q  <= 3'd0;
         sign_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (clr) begin
         err_q <= 1'b0;
      end else if (xfer) begin
         // A zero result is shown as an unsigned 0 regardless of what the
         // datapath put on the magnitude/sign lines.
         mag_q  <= res_zero ? 3'd0 : res_mag;
         sign_q <= res_sign && !res_zero;
         err_q  <= (res_zero && (res_mag != 3'd0)) || (!res_zero && (res_mag == 3'd0));
         div_q  <= '0;
         dsel_q <= 1'b0;
         hold_q <= '0;
      end else if (state_q == SHOW) begin
         if (div_q == DIV_LAST) begin
            div_q  <= '0;
            dsel_q <= ~dsel_q;
            if (!hold_done) begin
               hold_q <= hold_q + 1'b1;
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_display_driver.sv
// -----------------------------------------------------------------------------
// tb_result_display_driver
//
// Directed-vector bench for result_display_driver with REFRESH_DIV=4 and
// HOLD_SCANS=2. The stimulus process queues the expected display state for
// specific cycles; an independent monitor samples the DUT on the falling edge
// and checks every queued entry due for that cycle.
// -----------------------------------------------------------------------------
module tb_result_display_driver;

   logic       clk;
   logic       rst_n;
   logic       res_valid;
   logic       res_ready;
   logic [2:0] res_mag;
   logic       res_sign;
   logic       res_zero;
   logic       clr;
   logic [6:0] seg;
   logic [1:0] an;
   logic       err;

   result_display_driver #(
      .REFRESH_DIV(4),
      .HOLD_SCANS (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_mag  (res_mag),
      .res_sign (res_sign),
      .res_zero (res_zero),
      .clr      (clr),
      .seg      (seg),
      .an       (an),
      .err      (err)
   );

   typedef struct packed {
      int         cyc;
      logic [1:0] an;
      logic [6:0] seg;
      logic       rdy;
      logic       err;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   int cyc      = 0;
   int n_cmp    = 0;
   int n_fail   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Queue an expectation for cycle c, kept in cycle order.
   task automatic exp_at(input int c, input logic [1:0] a, input logic [6:0] s,
                         input logic r, input logic e, input string nm);
      exp_t x;
      int   pos;
      x.cyc = c; x.an = a; x.seg = s; x.rdy = r; x.err = e;
      pos = exp_q.size();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].cyc > c) begin
            pos = i;
            break;
         end
      end
      exp_q.insert(pos, x);
      name_q.insert(pos, nm);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic send(input logic [2:0] m, input logic s, input logic z, output int t);
      res_valid = 1'b1;
      res_mag   = m;
      res_sign  = s;
      res_zero  = z;
      step(1);
      res_valid = 1'b0;
      t = cyc;
   endtask

   // Expected view of one accepted result: magnitude digit right after the
   // accept, sign digit after the first slot toggle, magnitude again with
   // res_ready restored after the second toggle.
   task automatic check_show(input int t, input logic [6:0] mseg, input logic [6:0] sseg,
                             input logic e, input bit with_final, input string nm);
      exp_at(t,     2'b01, mseg, 1'b0, e, {nm, "_mag"});
      exp_at(t + 4, 2'b10, sseg, 1'b0, e, {nm, "_sgn"});
      if (with_final) exp_at(t + 8, 2'b01, mseg, 1'b1, e, {nm, "_rdy"});
   endtask

   // Monitor: compares every expectation due in the current cycle.
   initial begin
      exp_t  x;
      string nm;
      forever begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (x.cyc != cyc) begin
               n_fail++;
               $display("FAIL %s: checked at cycle %0d, required at cycle %0d", nm, cyc, x.cyc);
            end else if (an !== x.an || seg !== x.seg || res_ready !== x.rdy || err !== x.err) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got an=%b seg=%h rdy=%b err=%b, required an=%b seg=%h rdy=%b err=%b",
                        nm, cyc, an, seg, res_ready, err, x.an, x.seg, x.rdy, x.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t5, tc, c0;
      logic [6:0] segtab [8];
      logic       s;
      segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

      rst_n = 1'b0; res_valid = 1'b0; res_mag = 3'd0; res_sign = 1'b0;
      res_zero = 1'b0; clr = 1'b0;

      // Reset state, then 20 idle cycles.
      step(2);
      exp_at(cyc, 2'b00, 7'h00, 1'b1, 1'b0, "in_reset");
      step(1);
      rst_n = 1'b1;
      c0 = cyc;
      exp_at(c0,      2'b00, 7'h00, 1'b1, 1'b0, "reset");
      exp_at(c0 + 10, 2'b00, 7'h00, 1'b1, 1'b0, "idle10");
      exp_at(c0 + 20, 2'b00, 7'h00, 1'b1, 1'b0, "idle20");
      wait_until(c0 + 20);

      // -5, including the last held cycle before res_ready returns.
      send(3'd5, 1'b1, 1'b0, t);
      check_show(t, 7'h6D, 7'h40, 1'b0, 1'b1, "neg5");
      exp_at(t + 7, 2'b10, 7'h40, 1'b0, 1'b0, "neg5_hold_last");
      wait_until(t + 8);

      // Zero with sign set is normalised to an unsigned 0.
      send(3'd0, 1'b1, 1'b1, t);
      check_show(t, 7'h3F, 7'h00, 1'b0, 1'b1, "zero_norm");
      wait_until(t + 8);

      // mag=0 without zero flag: error, sign suppressed.
      send(3'd0, 1'b1, 1'b0, t);
      check_show(t, 7'h79, 7'h00, 1'b1, 1'b1, "err_mag0");
      wait_until(t + 8);

      // A consistent result clears err.
      send(3'd3, 1'b0, 1'b0, t);
      check_show(t, 7'h4F, 7'h00, 1'b0, 1'b1, "pos3");

      // res_valid held through the hold window: accepted at first ready edge.
      res_valid = 1'b1; res_mag = 3'd2; res_sign = 1'b0; res_zero = 1'b0;
      exp_at(t + 2, 2'b01, 7'h4F, 1'b0, 1'b0, "held_ignored");
      exp_at(t + 6, 2'b10, 7'h00, 1'b0, 1'b0, "held_ignored_sgn");
      wait_until(t + 9);
      res_valid = 1'b0;
      t5 = t + 9;
      check_show(t5, 7'h5B, 7'h00, 1'b0, 1'b0, "held_accept");

      // clr with res_valid in the same cycle: no transfer, back to BLANK.
      wait_until(t5 + 8);
      clr = 1'b1; res_valid = 1'b1; res_mag = 3'd7; res_sign = 1'b1;
      exp_at(t5 + 8, 2'b01, 7'h5B, 1'b0, 1'b0, "clr_blocks_ready");
      step(1);
      clr = 1'b0; res_valid = 1'b0;
      tc = cyc;
      exp_at(tc,     2'b00, 7'h00, 1'b1, 1'b0, "clr_blank");
      // clr while already BLANK is a no-op apart from dropping res_ready.
      step(1);
      clr = 1'b1;
      exp_at(tc + 1, 2'b00, 7'h00, 1'b0, 1'b0, "clr_in_blank");
      step(1);
      clr = 1'b0;
      exp_at(tc + 2, 2'b00, 7'h00, 1'b1, 1'b0, "blank_after_clr");
      exp_at(tc + 6, 2'b00, 7'h00, 1'b1, 1'b0, "blank_stays");
      wait_until(tc + 6);

      // Every magnitude digit, alternating sign.
      for (int i = 0; i < 8; i++) begin
         s = (i % 2) == 1;
         send(3'(i), s, i == 0, t);
         check_show(t, segtab[i], (s && i != 0) ? 7'h40 : 7'h00, 1'b0, 1'b1,
                    $sformatf("digit%0d", i));
         wait_until(t + 8);
      end

      // Zero flag with non-zero magnitude: error, then clr clears it.
      send(3'd4, 1'b1, 1'b1, t);
      check_show(t, 7'h79, 7'h00, 1'b1, 1'b0, "err_zflag");
      wait_until(t + 8);
      clr = 1'b1;
      exp_at(t + 8, 2'b01, 7'h79, 1'b0, 1'b1, "err_before_clr");
      step(1);
      clr = 1'b0;
      exp_at(cyc, 2'b00, 7'h00, 1'b1, 1'b0, "err_cleared");
      step(1);

      // Asynchronous reset mid-scan, sampled before any further clock edge.
      send(3'd6, 1'b1, 1'b0, t);
      exp_at(t, 2'b01, 7'h7D, 1'b0, 1'b0, "neg6");
      wait_until(t + 2);
      #1;
      rst_n = 1'b0;
      exp_at(t + 2, 2'b00, 7'h00, 1'b1, 1'b0, "async_reset");
      step(1);
      rst_n = 1'b1;
      exp_at(cyc,     2'b00, 7'h00, 1'b1, 1'b0, "post_reset");
      exp_at(cyc + 5, 2'b00, 7'h00, 1'b1, 1'b0, "post_reset_idle");

      step(8);
      while (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         n_cmp++;
         n_fail++;
         $display("FAIL %s: expectation never checked, required by cycle %0d", name_q.pop_front(), cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
